// File: rtl/fifo_burst_reader.sv
// Pulls a requested number of words from a show-ahead FIFO into a 2-entry skid buffer feeding a valid/ready stream.
// Define FIFO_BURST_READER_LAST_EN to add out_last, marking the final word of each burst.
module fifo_burst_reader #(
  parameter int WIDTH = 8,
  parameter int LENW  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_data,
  output logic             fifo_pop,
  input  logic             req_valid,
  input  logic [LENW-1:0]  req_len,
  output logic             req_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
`ifdef FIFO_BURST_READER_LAST_EN
  output logic             out_last,
`endif
  output logic             done
);

  typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_t;

  state_t           state;
  logic [LENW-1:0]  remaining;
  logic [1:0]       occ;
  logic [WIDTH-1:0] buf0;
  logic [WIDTH-1:0] buf1;
  logic             take;

  // Outputs are masked while rst is high so nothing leaks out of an aborted burst.
  assign req_ready = (state == IDLE) && !rst;
  assign out_valid = (occ != 2'd0) && !rst;
  assign out_data  = buf0;
  assign done      = (state == DRAIN) && (occ == 2'd0) && !rst;
  assign take      = out_valid && out_ready;
  assign fifo_pop  = !rst && (state == ACTIVE) && (remaining != '0) && !fifo_empty &&
                     ((occ < 2'd2) || ((occ == 2'd2) && out_ready));

`ifdef FIFO_BURST_READER_LAST_EN
  logic last0;
  logic last1;
  logic word_last;

  assign word_last = (remaining == LENW'(1));
  assign out_last  = out_valid && last0;

  always_ff @(posedge clk) begin
    if (rst) begin
      last0 <= 1'b0;
      last1 <= 1'b0;
    end else begin
      case ({fifo_pop, take})
        2'b10: begin
          if (occ == 2'd0) last0 <= word_last;
          else             last1 <= word_last;
        end
        2'b01: last0 <= last1;
        2'b11: begin
          if (occ == 2'd1) begin
            last0 <= word_last;
          end else begin
            last0 <= last1;
            last1 <= word_last;
          end
        end
        default: ;
      endcase
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      remaining <= '0;
      occ       <= '0;
      buf0      <= '0;
      buf1      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            remaining <= req_len;
            state     <= (req_len == '0) ? DRAIN : ACTIVE;
          end
        end
        ACTIVE: begin
          if (remaining == '0)
            state <= DRAIN;
          else if (fifo_pop)
            remaining <= remaining - LENW'(1);
        end
        DRAIN: begin
          if (occ == 2'd0)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // buf0 is always the oldest entry; a pop at occ==2 only happens alongside a take.
      case ({fifo_pop, take})
        2'b10: begin
          if (occ == 2'd0) buf0 <= fifo_data;
          else             buf1 <= fifo_data;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          buf0 <= buf1;
          occ  <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd1) begin
            buf0 <= fifo_data;
          end else begin
            buf0 <= buf1;
            buf1 <= fifo_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Self-checking bench for fifo_burst_reader: a show-ahead FIFO model feeds the DUT, a scoreboard checks the stream.
module tb_fifo_burst_reader;

  logic       clk = 1'b0;
  logic       rst;
  logic       fifo_empty;
  logic [7:0] fifo_data;
  logic       fifo_pop;
  logic       req_valid;
  logic [7:0] req_len;
  logic       req_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;
  logic       done;
`ifdef FIFO_BURST_READER_LAST_EN
  logic       out_last;
`endif

  always #5 clk = ~clk;

  fifo_burst_reader #(.WIDTH(8), .LENW(8)) dut (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_data(fifo_data), .fifo_pop(fifo_pop),
    .req_valid(req_valid), .req_len(req_len), .req_ready(req_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
`ifdef FIFO_BURST_READER_LAST_EN
    .out_last(out_last),
`endif
    .done(done)
  );

  // FIFO model: fmem written by stimulus, rd_ptr advanced by the DUT's pops.
  logic [7:0] fmem [256];
  logic [7:0] wr_ptr = '0;
  logic [7:0] rd_ptr = '0;
  logic       clr = 1'b0;
  assign fifo_empty = (rd_ptr == wr_ptr);
  assign fifo_data  = fmem[rd_ptr];

  int pop_cnt = 0, done_cnt = 0, acc_cnt = 0, bad_pop = 0;
  int checks = 0, errors = 0;
  logic [8:0] exp_q [$];

  always @(posedge clk) begin
    if (clr) rd_ptr <= wr_ptr;
    else if (fifo_pop) rd_ptr <= rd_ptr + 8'd1;
    if (fifo_pop) pop_cnt <= pop_cnt + 1;
    if (fifo_pop && fifo_empty) bad_pop <= bad_pop + 1;
    if (done) done_cnt <= done_cnt + 1;
    if (req_valid && req_ready) acc_cnt <= acc_cnt + 1;
  end

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic push(input logic [7:0] d, input bit to_sb, input bit last);
    fmem[wr_ptr] = d;
    wr_ptr = wr_ptr + 8'd1;
    if (to_sb) exp_q.push_back({last, d});
  endtask

  // Returns at the negedge of the first cycle after the request is accepted.
  task automatic issue_req(input logic [7:0] len);
    req_len = len;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; req_valid = 1'b1; req_len = 8'd3; out_ready = 1'b1;
    push(8'hEE, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if ({out_valid, fifo_pop, done, req_ready} !== 4'b0000) begin
        errors++;
        $display("FAIL reset_outputs: got valid/pop/done/ready=%b expected 0000", {out_valid, fifo_pop, done, req_ready});
      end
    end
    rst = 1'b0; req_valid = 1'b0; clr = 1'b1;
    tick();
    clr = 1'b0;
    checks++;
    if ({req_ready, out_valid, done, fifo_pop} !== 4'b1000) begin
      errors++;
      $display("FAIL post_reset: got ready/valid/done/pop=%b expected 1000", {req_ready, out_valid, done, fifo_pop});
    end
    checks++;
    if (acc_cnt !== 0) begin
      errors++;
      $display("FAIL reset_accept: got %0d accepts expected 0", acc_cnt);
    end
  endtask

  task automatic test_basic;
    bit ep [6] = '{1, 1, 1, 0, 0, 0};
    bit ev [6] = '{0, 1, 1, 1, 0, 0};
    bit ed [6] = '{0, 0, 0, 0, 1, 0};
    logic [8:0] e, got;
    push(8'h11, 1'b1, 1'b0); push(8'h22, 1'b1, 1'b0); push(8'h33, 1'b1, 1'b1);
    out_ready = 1'b1;
    issue_req(8'd3);
    for (int i = 0; i < 6; i++) begin
      checks++;
      if ({fifo_pop, out_valid, done} !== {ep[i], ev[i], ed[i]}) begin
        errors++;
        $display("FAIL basic_cycle%0d: got pop/valid/done=%b expected %b", i, {fifo_pop, out_valid, done}, {ep[i], ev[i], ed[i]});
      end
      if (out_valid && out_ready) begin
        checks++;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 9'h1XX;
`ifdef FIFO_BURST_READER_LAST_EN
        got = {out_last, out_data};
`else
        got = {e[8], out_data};
`endif
        if (got !== e) begin
          errors++;
          $display("FAIL basic_data: got %h expected %h", got, e);
        end
      end
      tick();
    end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL basic_ready: got %b expected 1", req_ready);
    end
  endtask

  task automatic test_backpressure;
    int p0, d0;
    bit fin;
    logic [8:0] e, got;
    push(8'h41, 1'b1, 1'b0); push(8'h42, 1'b1, 1'b0); push(8'h43, 1'b1, 1'b0); push(8'h44, 1'b1, 1'b1);
    out_ready = 1'b0; p0 = pop_cnt; d0 = done_cnt;
    issue_req(8'd4);
    for (int i = 0; i < 6; i++) begin
      if (out_valid) begin
        checks++;
        if (out_data !== 8'h41) begin
          errors++;
          $display("FAIL bp_hold: got %h expected 41", out_data);
        end
      end
      tick();
    end
    checks++;
    if ({pop_cnt - p0, fifo_pop, out_valid} !== {32'd2, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL bp_stall: got pops=%0d pop=%b valid=%b expected pops=2 pop=0 valid=1", pop_cnt - p0, fifo_pop, out_valid);
    end
    out_ready = 1'b1; fin = 1'b0;
    for (int i = 0; i < 30 && !fin; i++) begin
      if (out_valid && out_ready) begin
        checks++;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 9'h1XX;
`ifdef FIFO_BURST_READER_LAST_EN
        got = {out_last, out_data};
`else
        got = {e[8], out_data};
`endif
        if (got !== e) begin
          errors++;
          $display("FAIL bp_data: got %h expected %h", got, e);
        end
      end
      if (done) fin = 1'b1;
      tick();
    end
    tick();
    checks++;
    if (!fin || done_cnt - d0 != 1 || pop_cnt - p0 != 4 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL bp_complete: got done=%0d pops=%0d left=%0d expected done=1 pops=4 left=0", done_cnt - d0, pop_cnt - p0, exp_q.size());
    end
  endtask

  task automatic test_starvation;
    int d0;
    bit fin;
    logic [8:0] e, got;
    out_ready = 1'b1; d0 = done_cnt;
    issue_req(8'd2);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({fifo_pop, out_valid, done} !== 3'b000) begin
        errors++;
        $display("FAIL starve_idle: got pop/valid/done=%b expected 000", {fifo_pop, out_valid, done});
      end
      tick();
    end
    push(8'hA5, 1'b1, 1'b0); push(8'h5A, 1'b1, 1'b1);
    fin = 1'b0;
    for (int i = 0; i < 20 && !fin; i++) begin
      if (out_valid && out_ready) begin
        checks++;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 9'h1XX;
`ifdef FIFO_BURST_READER_LAST_EN
        got = {out_last, out_data};
`else
        got = {e[8], out_data};
`endif
        if (got !== e) begin
          errors++;
          $display("FAIL starve_data: got %h expected %h", got, e);
        end
      end
      if (done) fin = 1'b1;
      tick();
    end
    checks++;
    if (!fin || done_cnt - d0 != 1 || exp_q.size() != 0 || bad_pop != 0) begin
      errors++;
      $display("FAIL starve_complete: got done=%0d left=%0d bad_pops=%0d expected 1/0/0", done_cnt - d0, exp_q.size(), bad_pop);
    end
  endtask

  task automatic test_zero_len;
    int p0, d0;
    bit fin;
    push(8'h77, 1'b0, 1'b0);
    p0 = pop_cnt; d0 = done_cnt; fin = 1'b0;
    issue_req(8'd0);
    for (int i = 0; i < 2 && !fin; i++) begin
      if (done) fin = 1'b1;
      tick();
    end
    checks++;
    if (!fin || req_ready !== 1'b1 || pop_cnt != p0 || done_cnt - d0 != 1) begin
      errors++;
      $display("FAIL zero_len: got done_seen=%b ready=%b pops=%0d dones=%0d expected 1/1/0/1", fin, req_ready, pop_cnt - p0, done_cnt - d0);
    end
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic test_mid_reset;
    int p0, d0;
    bit fin;
    logic [8:0] e, got;
    for (int i = 0; i < 8; i++) push(8'h80 + 8'(i), 1'b1, i == 7);
    out_ready = 1'b1; p0 = pop_cnt; d0 = done_cnt;
    issue_req(8'd8);
    for (int i = 0; i < 20 && (pop_cnt - p0) < 3; i++) begin
      if (out_valid && out_ready) begin
        checks++;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 9'h1XX;
`ifdef FIFO_BURST_READER_LAST_EN
        got = {out_last, out_data};
`else
        got = {e[8], out_data};
`endif
        if (got !== e) begin
          errors++;
          $display("FAIL mid_pre_data: got %h expected %h", got, e);
        end
      end
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0; clr = 1'b1;
    exp_q.delete();
    tick();
    clr = 1'b0;
    checks++;
    if ({out_valid, req_ready, done, fifo_pop} !== 4'b0100 || done_cnt != d0 || pop_cnt - p0 != 3) begin
      errors++;
      $display("FAIL mid_abort: got valid/ready/done/pop=%b dones=%0d pops=%0d expected 0100 0 3", {out_valid, req_ready, done, fifo_pop}, done_cnt - d0, pop_cnt - p0);
    end
    push(8'h99, 1'b1, 1'b1);
    fin = 1'b0;
    issue_req(8'd1);
    for (int i = 0; i < 20 && !fin; i++) begin
      if (out_valid && out_ready) begin
        checks++;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 9'h1XX;
`ifdef FIFO_BURST_READER_LAST_EN
        got = {out_last, out_data};
`else
        got = {e[8], out_data};
`endif
        if (got !== e) begin
          errors++;
          $display("FAIL mid_post_data: got %h expected %h", got, e);
        end
      end
      if (done) fin = 1'b1;
      tick();
    end
    checks++;
    if (!fin || done_cnt - d0 != 1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL mid_post_complete: got done=%0d left=%0d expected 1/0", done_cnt - d0, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_starvation();
    test_zero_len();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_burst_reader.md
FIFO_BURST_READER -- requirements
Module: fifo_burst_reader

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data word width.
REQ-002 SHALL have parameter LENW, default 8, burst-length field width.
REQ-003 SHALL have port clk, input, 1, clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-005 SHALL have port fifo_empty, input, 1, FIFO empty flag.
REQ-006 SHALL have port fifo_data, input, WIDTH, FIFO head word, combinational and valid whenever fifo_empty=0.
REQ-007 SHALL have port fifo_pop, output, 1, FIFO pop strobe, combinational.
REQ-008 SHALL have port req_valid, input, 1, burst request valid.
REQ-009 SHALL have port req_len, input, LENW, number of words in the burst.
REQ-010 SHALL have port req_ready, output, 1, request accepted when req_valid and req_ready are both 1.
REQ-011 SHALL have port out_valid, output, 1, stream word valid.
REQ-012 SHALL have port out_data, output, WIDTH, stream word.
REQ-013 SHALL have port out_ready, input, 1, downstream accepts word.
REQ-014 SHALL have port done, output, 1, one-cycle burst-complete pulse.

Function
REQ-015 SHALL implement FSM states IDLE, ACTIVE, DRAIN; req_ready = (state==IDLE).
REQ-016 SHALL, on request accept in IDLE: load remaining=req_len, enter ACTIVE next cycle; if req_len=0, enter DRAIN directly.
REQ-017 SHALL hold a 2-entry output skid buffer; occupancy 0..2; out_valid=(occ!=0); out_data=oldest entry.
REQ-018 SHALL assert fifo_pop = ACTIVE & remaining!=0 & !fifo_empty & (occ<2 | (occ==2 & out_ready)).
REQ-019 SHALL write fifo_data into the buffer in the same cycle as fifo_pop; word visible on out_data the next cycle (latency 1).
REQ-020 SHALL, on simultaneous pop and output handshake, keep occupancy unchanged and preserve word order.
REQ-021 SHALL decrement remaining on each pop; remaining never wraps below 0.
REQ-022 SHALL transition ACTIVE->DRAIN in the cycle after remaining reaches 0.
REQ-023 SHALL, in DRAIN, when occ becomes 0 (or already 0), pulse done for exactly one cycle and return to IDLE in the same cycle as done.
REQ-024 SHALL stall without loss while fifo_empty=1 or out_ready=0; out_data stable while out_valid=1 and out_ready=0.
REQ-025 SHALL never pop when fifo_empty=1 and never accept a new request before done.

Reset
REQ-026 SHALL, on rst=1, set state=IDLE, remaining=0, occ=0, buffer contents discarded.
REQ-027 SHALL drive during and right after reset: out_valid=0, done=0, fifo_pop=0, req_ready=1 (once rst deasserted).
REQ-028 SHALL abort an in-progress burst on mid-operation reset; no done pulse issued for it.

Configuration
REQ-029 SHALL, with macro FIFO_BURST_READER_LAST_EN defined, add output out_last (1 bit), asserted with out_valid on the final word of a burst; buffer stores a last flag per entry.
REQ-030 SHALL, without FIFO_BURST_READER_LAST_EN, omit out_last port and flag storage; all other behaviour identical.

Verification
REQ-031 Reset: rst=1 two cycles with req_valid=1 -> out_valid=0, fifo_pop=0, done=0, no request accepted.
REQ-032 Basic burst: FIFO holds 0x11,0x22,0x33; req_len=3, out_ready=1 -> pops on 3 consecutive cycles, out_data 0x11,0x22,0x33 each one cycle after its pop, done one cycle after 0x33 accepted.
REQ-033 Backpressure: req_len=4, out_ready=0 -> exactly 2 pops then fifo_pop=0, out_data holds first word; out_ready=1 -> remaining 2 popped, order preserved, done pulses once.
REQ-034 Starvation: req_len=2, FIFO empty 5 cycles then 0xA5,0x5A pushed -> no pops while empty, then output 0xA5,0x5A, done.
REQ-035 Zero length: req_len=0 -> no pop, done pulses within 2 cycles of accept, req_ready returns to 1.
REQ-036 Mid-burst reset: req_len=8, rst asserted after 3 pops -> next cycle out_valid=0, state IDLE, no done; new req_len=1 completes normally; with FIFO_BURST_READER_LAST_EN, out_last=1 only on that final word.
